// File: rtl/binary_bbox_detect.sv
// Bounding-box detector for a binary (mask) video stream.
// Tracks the min/max column and row of foreground pixels over one frame,
// counts them, and on the next frame-sync rising edge publishes the box,
// its centre, the count and a validity flag (count >= MIN_PIX).
module binary_bbox_detect #(
  parameter int DW      = 24,
  parameter int H_BITS  = 12,
  parameter int V_BITS  = 12,
  parameter int MIN_PIX = 64
) (
  input  logic              pixelclk,
  input  logic              reset_n,
  input  logic [DW-1:0]     i_binary,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_de,
  output logic [H_BITS-1:0] o_x_min,
  output logic [H_BITS-1:0] o_x_max,
  output logic [V_BITS-1:0] o_y_min,
  output logic [V_BITS-1:0] o_y_max,
  output logic [H_BITS-1:0] o_cx,
  output logic [V_BITS-1:0] o_cy,
  output logic [23:0]       o_pix_cnt,
  output logic              o_valid,
  output logic              o_frame_done
);

  localparam logic [H_BITS-1:0] X_ONES   = {H_BITS{1'b1}};
  localparam logic [V_BITS-1:0] Y_ONES   = {V_BITS{1'b1}};
  localparam logic [23:0]       CNT_ONES = 24'hFFFFFF;
  localparam logic [23:0]       MIN_CNT  = 24'(MIN_PIX);

  typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  function automatic logic [H_BITS-1:0] sat_inc_x(input logic [H_BITS-1:0] v);
    return (v == X_ONES) ? v : v + 1'b1;
  endfunction

  function automatic logic [V_BITS-1:0] sat_inc_y(input logic [V_BITS-1:0] v);
    return (v == Y_ONES) ? v : v + 1'b1;
  endfunction

  function automatic logic [23:0] sat_inc_cnt(input logic [23:0] v);
    return (v == CNT_ONES) ? v : v + 1'b1;
  endfunction

  // i_hsync is part of the video bus but line timing is derived from de.
  logic unused_hsync;
  assign unused_hsync = i_hsync;

  logic fg_q, de_q, vs_q, de_qq, vs_qq;
  state_t state_q, state_d;
  logic [H_BITS-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [V_BITS-1:0] y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [23:0]       cnt_q, cnt_d;
  logic [H_BITS:0]   sum_x;
  logic [V_BITS:0]   sum_y;
  logic              vs_rise, de_fall, frame_clr, latch_en, accum_en, is_valid;

  // Input stage plus one-cycle-delayed copies for edge detection.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      fg_q  <= 1'b0;
      de_q  <= 1'b0;
      vs_q  <= 1'b0;
      de_qq <= 1'b0;
      vs_qq <= 1'b0;
    end else begin
      fg_q  <= |i_binary;
      de_q  <= i_de;
      vs_q  <= i_vsync;
      de_qq <= de_q;
      vs_qq <= vs_q;
    end
  end

  assign vs_rise = vs_q & ~vs_qq;
  assign de_fall = ~de_q & de_qq;

  // FSM state register.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: the first frame sync only arms accumulation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_rise) state_d = ACCUM;
      ACCUM:   if (vs_rise) state_d = LATCH;
      LATCH:   state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: a pixel coincident with the sync edge belongs to no frame.
  always_comb begin
    latch_en = 1'b0;
    accum_en = 1'b0;
    case (state_q)
      ACCUM:   accum_en = de_q & fg_q & ~vs_rise;
      LATCH:   latch_en = 1'b1;
      default: ;
    endcase
  end

  assign frame_clr = vs_rise | latch_en;

  // Column/row counters; the sync edge also zeroes them so the first
  // accumulated frame starts from the origin.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_clr) begin
      x_d = '0;
      y_d = '0;
    end else begin
      if (de_q)         x_d = sat_inc_x(x_q);
      else if (de_fall) x_d = '0;
      if (de_fall)      y_d = sat_inc_y(y_q);
    end
  end

  // Running extents and count, reinitialised in the latch cycle.
  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (latch_en) begin
      xmin_d = X_ONES;
      xmax_d = '0;
      ymin_d = Y_ONES;
      ymax_d = '0;
      cnt_d  = '0;
    end else if (accum_en) begin
      if (x_q < xmin_q) xmin_d = x_q;
      if (x_q > xmax_q) xmax_d = x_q;
      if (y_q < ymin_q) ymin_d = y_q;
      if (y_q > ymax_q) ymax_d = y_q;
      cnt_d = sat_inc_cnt(cnt_q);
    end
  end

  // Counter and running-statistic registers.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      xmin_q <= X_ONES;
      xmax_q <= '0;
      ymin_q <= Y_ONES;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      cnt_q  <= cnt_d;
    end
  end

  // One extra bit keeps min+max from overflowing before the halving.
  assign sum_x    = {1'b0, xmin_q} + {1'b0, xmax_q};
  assign sum_y    = {1'b0, ymin_q} + {1'b0, ymax_q};
  assign is_valid = (cnt_q >= MIN_CNT);

  // Published results; box and centre hold when the frame is not valid.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      o_x_min      <= '0;
      o_x_max      <= '0;
      o_y_min      <= '0;
      o_y_max      <= '0;
      o_cx         <= '0;
      o_cy         <= '0;
      o_pix_cnt    <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= latch_en;
      if (latch_en) begin
        o_pix_cnt <= cnt_q;
        o_valid   <= is_valid;
        if (is_valid) begin
          o_x_min <= xmin_q;
          o_x_max <= xmax_q;
          o_y_min <= ymin_q;
          o_y_max <= ymax_q;
          o_cx    <= sum_x[H_BITS:1];
          o_cy    <= sum_y[V_BITS:1];
        end
      end
    end
  end

endmodule

// File: doc/binary_bbox_detect.md
BINARY_BBOX_DETECT -- requirements
Module: binary_bbox_detect

Interface
REQ-001 SHALL have parameter DW, default 24, giving the binary/video data width.
REQ-002 SHALL have parameter H_BITS, default 12, giving the column coordinate width.
REQ-003 SHALL have parameter V_BITS, default 12, giving the row coordinate width.
REQ-004 SHALL have parameter MIN_PIX, default 64, giving the minimum foreground count for a valid target.
REQ-005 SHALL have port pixelclk, input, 1: pixel clock; all logic is on the rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_binary, input, DW: mask pixel; any nonzero value is foreground.
REQ-008 SHALL have port i_hsync, input, 1: line sync; not used for counting.
REQ-009 SHALL have port i_vsync, input, 1: frame sync, active-high.
REQ-010 SHALL have port i_de, input, 1: active-pixel qualifier.
REQ-011 SHALL have ports o_x_min and o_x_max, output, H_BITS each: bounding-box columns.
REQ-012 SHALL have ports o_y_min and o_y_max, output, V_BITS each: bounding-box rows.
REQ-013 SHALL have ports o_cx, output, H_BITS and o_cy, output, V_BITS: box centre.
REQ-014 SHALL have port o_pix_cnt, output, 24: foreground pixel count of the last frame.
REQ-015 SHALL have port o_valid, output, 1: last frame contained a valid target.
REQ-016 SHALL have port o_frame_done, output, 1: one-cycle pulse when outputs update.

Function
REQ-017 SHALL register i_binary, i_de and i_vsync in one input stage; all further logic uses these registered copies.
REQ-018 SHALL keep a column counter x: it increments on each registered de-high cycle, starts at 0 for the first pixel of a line, and clears on the cycle after the de falling edge.
REQ-019 SHALL increment row counter y on each registered de falling edge and clear it at frame end.
REQ-020 SHALL saturate x at 2^H_BITS-1 and y at 2^V_BITS-1, with no wrap.
REQ-021 SHALL use three states: IDLE, ACCUM and LATCH.
REQ-022 IDLE SHALL be entered at reset; it discards all pixels and goes to ACCUM on the first registered vsync rising edge, so the partial first frame is ignored.
REQ-023 ACCUM SHALL, for each registered de-high foreground pixel, update the running min/max of x and y and increment the running count, saturating at 2^24-1.
REQ-024 ACCUM SHALL go to LATCH on a registered vsync rising edge.
REQ-025 LATCH SHALL last exactly one cycle, then return to ACCUM.
REQ-026 In LATCH, o_frame_done SHALL be 1 and o_pix_cnt SHALL load the running count.
REQ-027 In LATCH, o_valid SHALL be set to (count >= MIN_PIX).
REQ-028 In LATCH, if valid, the bbox outputs SHALL load the running min/max values.
REQ-029 In LATCH, if valid, o_cx SHALL load (x_min+x_max)>>1 and o_cy SHALL load (y_min+y_max)>>1, computed with a 1-bit-wider sum and no overflow.
REQ-030 In LATCH, if not valid, the bbox and centre outputs SHALL hold their previous values.
REQ-031 In LATCH, the running min SHALL be reinitialised to all-ones, the running max and count to 0, and x and y to 0.
REQ-032 o_frame_done SHALL assert exactly at clock edge N+2, where N is the first edge sampling i_vsync=1 after sampling 0.
REQ-033 A pixel with i_de=1 in the same cycle as the vsync rising edge SHALL be dropped and not counted in either frame.
REQ-034 A frame with no foreground SHALL give o_pix_cnt=0 and o_valid=0, with the bbox outputs unchanged.
REQ-035 i_vsync held high for many cycles SHALL produce only one LATCH.

Reset
REQ-036 On reset_n=0, all outputs SHALL be 0 immediately.
REQ-037 On reset_n=0, the FSM SHALL be in IDLE, the running min registers all-ones, and the max registers, count and counters 0.
REQ-038 Reset asserted mid-frame SHALL discard that frame; the next update follows the second vsync rising edge after release.

Verification
REQ-039 SHALL test: MIN_PIX=4, 16x8 frames, foreground rectangle at columns 3..6, rows 2..4 -> x_min=3, x_max=6, y_min=2, y_max=4, cx=4, cy=3, pix_cnt=12, valid=1, and frame_done for one cycle.
REQ-040 SHALL test: an all-zero frame following the previous case -> pix_cnt=0, valid=0, bbox still 3/6/2/4.
REQ-041 SHALL test: MIN_PIX=4, a single foreground pixel at (15,7) -> pix_cnt=1, valid=0; then a 2x2 block at (14..15, 6..7) -> box 14/15/6/7, cx=14, cy=6.
REQ-042 SHALL test: reset released mid-frame with foreground present -> the first frame_done occurs only after the second vsync rising edge, and the partial frame is not counted.
REQ-043 SHALL test: i_vsync high for 20 cycles -> exactly one frame_done pulse, at edge N+2.
REQ-044 SHALL test: de=1 with foreground coincident with the vsync rising edge -> that pixel is absent from pix_cnt.
